spi_mem_responder: RTL and testbench

//  SPI mode-0 target that answers the 0x03 (read) and 0x02 (write) commands with a 24-bit address.

---
 rtl/spi_mem_responder_if.sv | 25 ++
 rtl/spi_mem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_responder_if.sv
// ---------------------------------------------------------------------------
// spi_mem_responder_if
//   Four-wire SPI bus between an initiator and the memory responder.
//   Signals:
//     sclk     SPI clock, driven by the initiator
//     cs_n     chip select, active-low, driven by the initiator
//     mosi     initiator -> target serial data, MSB first
//     miso     target -> initiator serial data, MSB first
//     miso_oe  1 while the target is actively driving miso
//   Modports:
//     master   initiator side
//     slave    target side (spi_mem_responder)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_mem_responder_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_mem_responder.sv
// ---------------------------------------------------------------------------
// spi_mem_responder
//   SPI mode-0 target serving 0x03 (read) and 0x02 (write) commands with a
//   24-bit address, backed by a 2**ADDR_BITS byte array. All SPI inputs are
//   oversampled in the clk domain; there is no second clock domain.
//   Ports:
//     clk        system clock
//     rst_n      synchronous active-low reset (clears the byte array too)
//     spi        SPI bus, slave modport (sclk, cs_n, mosi in; miso, miso_oe out)
//     cmd_err    1-clk pulse when the command byte is neither 0x02 nor 0x03
//     xfer_done  1-clk pulse on deselect of a frame that reached RD or WR
//     dbg_addr   backdoor read address
//     dbg_rdata  mem[dbg_addr], registered, 1-clk latency
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_mem_responder #(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_mem_responder_if.slave   spi,
    output logic                 cmd_err,
    output logic                 xfer_done,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [7:0]           dbg_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } state_t;

    // 2-FF synchronisers; index 1 is the synchronised sample.
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;

    // Set once cs_n has been seen high, so a frame already in progress at
    // reset release is never joined partway through.
    logic       armed;

    state_t                state;
    logic [4:0]            bit_cnt;
    logic [6:0]            rx_sr;     // bits received so far in the current byte
    logic [6:0]            tx_sr;     // remaining bits of the byte on miso
    logic [ADDR_BITS-1:0]  ptr;
    logic                  writing;
    logic                  rd_first;  // next fall in RD loads mem[ptr] without incrementing
    logic [7:0]            mem [DEPTH];

    logic                  sclk_s;
    logic                  cs_s;
    logic                  mosi_s;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  cs_rise;
    logic                  cs_fall;
    logic [7:0]            rx_byte;
    logic [ADDR_BITS-1:0]  ptr_inc;

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise =  sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s &  sclk_prev;
    assign cs_rise   =  cs_s   & ~cs_prev;
    assign cs_fall   = ~cs_s   &  cs_prev;
    assign rx_byte   = {rx_sr, mosi_s};
    assign ptr_inc   = ptr + 1'b1;   // wraps modulo DEPTH by width

    // NOTE: every register here uses <= so all reads in this block see the
    // values from before the clock edge, e.g. dbg_rdata returns the old byte
    // when an SPI write hits the same address in the same clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // The cs_n synchroniser resets to 0 (not 1) so that a cs_n held
            // low through reset cannot arm the block.
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
            armed     <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            ptr       <= '0;
            writing   <= 1'b0;
            rd_first  <= 1'b0;
            spi.miso    <= 1'b0;
            spi.miso_oe <= 1'b0;
            cmd_err   <= 1'b0;
            xfer_done <= 1'b0;
            dbg_rdata <= '0;
            // NOTE: the byte array is cleared by reset, so it is built from
            // flops rather than a RAM macro; the loop unrolls into DEPTH
            // parallel clears.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk};
            cs_sync   <= {cs_sync[0],   spi.cs_n};
            mosi_sync <= {mosi_sync[0], spi.mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            dbg_rdata <= mem[dbg_addr];
            cmd_err   <= 1'b0;
            xfer_done <= 1'b0;

            if (cs_s) begin
                // Deselect wins over any sclk edge seen in the same clk.
                armed       <= 1'b1;
                state       <= IDLE;
                bit_cnt     <= '0;
                spi.miso    <= 1'b0;
                spi.miso_oe <= 1'b0;
                xfer_done   <= cs_rise && (state == RD || state == WR);
            end else begin
                case (state)
                    IDLE: begin
                        if (armed && cs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (sclk_rise) begin
                            rx_sr <= rx_byte[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (rx_byte)
                                    8'h03: begin
                                        state   <= ADDR;
                                        writing <= 1'b0;
                                    end
                                    8'h02: begin
                                        state   <= ADDR;
                                        writing <= 1'b1;
                                    end
                                    default: begin
                                        state   <= IGNORE;
                                        cmd_err <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ADDR: begin
                        // Shifting straight into ptr keeps only the last
                        // ADDR_BITS address bits; the upper ones fall off.
                        if (sclk_rise) begin
                            ptr <= {ptr[ADDR_BITS-2:0], mosi_s};
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= '0;
                                rd_first <= 1'b1;
                                state    <= writing ? WR : RD;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    RD: begin
                        if (sclk_rise) begin
                            bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                        end else if (sclk_fall) begin
                            spi.miso_oe <= 1'b1;
                            if (bit_cnt == 5'd0) begin
                                // Byte boundary: first byte of the frame, or
                                // the fall after the 8th rise of a data byte.
                                if (rd_first) begin
                                    rd_first <= 1'b0;
                                    tx_sr    <= mem[ptr][6:0];
                                    spi.miso <= mem[ptr][7];
                                end else begin
                                    ptr      <= ptr_inc;
                                    tx_sr    <= mem[ptr_inc][6:0];
                                    spi.miso <= mem[ptr_inc][7];
                                end
                            end else begin
                                tx_sr    <= {tx_sr[5:0], 1'b0};
                                spi.miso <= tx_sr[6];
                            end
                        end
                    end

                    WR: begin
                        if (sclk_rise) begin
                            rx_sr <= rx_byte[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt  <= '0;
                                mem[ptr] <= rx_byte;
                                ptr      <= ptr_inc;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    IGNORE: begin
                        spi.miso    <= 1'b0;
                        spi.miso_oe <= 1'b0;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_mem_responder
//   Self-checking bench for spi_mem_responder. Acts as the SPI initiator
//   (mode 0, sclk = clk/10), keeps a byte-array reference model of the
//   target, and checks directed frames, a reset-mid-frame sequence and
//   randomised frames.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_mem_responder;

    localparam int AB    = 6;
    localparam int DEPTH = 64;
    localparam int HALF  = 5;   // sclk half-period in clk cycles

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AB-1:0] dbg_addr = '0;
    logic [7:0]    dbg_rdata;
    logic          cmd_err;
    logic          xfer_done;

    spi_mem_responder_if spi();

    spi_mem_responder #(.ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi),
        .cmd_err   (cmd_err),
        .xfer_done (xfer_done),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         err_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] ref_mem [DEPTH];

    // Every clk that a pulse output is high counts once, so a stretched
    // pulse shows up as an extra count.
    always @(negedge clk) begin
        if (cmd_err === 1'b1)   err_cnt++;
        if (xfer_done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          hdr_bits;   // leading bits of {cmd, addr} actually sent
        logic [31:0] data;       // right-justified, sent MSB first
        int          data_bits;
        logic [31:0] exp_rd;     // right-justified miso bits of the data phase
        int          exp_err;
        int          exp_done;
        logic [5:0]  ca0;
        logic [7:0]  cv0;
        logic [5:0]  ca1;
        logic [7:0]  cv1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dbg_read(input logic [5:0] a, output logic [7:0] v);
        @(negedge clk);
        dbg_addr = a;
        @(negedge clk);
        v = dbg_rdata;
    endtask

    // One mode-0 bit: mosi set while sclk low, miso sampled just before the rise.
    task automatic send_bit(input logic b, output logic so, output logic soe);
        spi.mosi = b;
        wait_clk(HALF);
        so  = spi.miso;
        soe = spi.miso_oe;
        spi.sclk = 1'b1;
        wait_clk(HALF);
        spi.sclk = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [23:0] addr, input int hdr_bits,
                             input logic [31:0] data, input int data_bits,
                             output logic [31:0] rd, output int oe_bad);
        logic [31:0] hdr;
        logic        b, so, soe, exp_oe, rd_frame;
        hdr      = {cmd, addr};
        rd_frame = (cmd == 8'h03) && (hdr_bits == 32);
        rd       = '0;
        oe_bad   = 0;
        spi.cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < hdr_bits + data_bits; i++) begin
            b = (i < hdr_bits) ? hdr[31 - i] : data[data_bits - 1 - (i - hdr_bits)];
            send_bit(b, so, soe);
            exp_oe = rd_frame && (i >= hdr_bits);
            if (i >= hdr_bits) rd = {rd[30:0], so};
            if (soe !== exp_oe || (!exp_oe && so !== 1'b0)) oe_bad++;
        end
        wait_clk(HALF);
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        wait_clk(8);
    endtask

    // Reference model: frame-level effect on the array and expected outputs.
    task automatic model_frame(input logic [7:0] cmd, input logic [23:0] addr, input int hdr_bits,
                               input logic [31:0] data, input int data_bits,
                               output logic [31:0] exp_rd, output int exp_err, output int exp_done);
        int  p;
        bit  valid;
        logic [7:0] byte_v;
        valid    = (hdr_bits == 32) && (cmd == 8'h02 || cmd == 8'h03);
        exp_err  = (hdr_bits >= 8 && !(cmd == 8'h02 || cmd == 8'h03)) ? 1 : 0;
        exp_done = valid ? 1 : 0;
        exp_rd   = '0;
        if (valid) begin
            p = int'(addr) % DEPTH;
            if (cmd == 8'h03) begin
                for (int i = 0; i < data_bits; i++) begin
                    byte_v = ref_mem[(p + i / 8) % DEPTH];
                    exp_rd = {exp_rd[30:0], byte_v[7 - i % 8]};
                end
            end else begin
                for (int k = 0; k < data_bits / 8; k++) begin
                    ref_mem[(p + k) % DEPTH] = data[data_bits - 1 - 8 * k -: 8];
                end
            end
        end
    endtask

    initial begin
        vec_t        vecs [11];
        logic [31:0] rd, m_rd;
        int          oe_bad, e0, d0, m_err, m_done, bad;
        logic [7:0]  v, cmd;
        logic [23:0] addr;
        logic [31:0] data;
        int          hb, db, r;
        logic        so, soe;

        vecs[0]  = '{8'h02, 24'h000010, 32, 32'hAA55, 16, 32'h0,      0, 1, 6'h10, 8'hAA, 6'h11, 8'h55};
        vecs[1]  = '{8'h03, 24'h000010, 32, 32'h0,    16, 32'hAA55,   0, 1, 6'h10, 8'hAA, 6'h11, 8'h55};
        vecs[2]  = '{8'h02, 24'h00003F, 32, 32'h1122, 16, 32'h0,      0, 1, 6'h3F, 8'h11, 6'h00, 8'h22};
        vecs[3]  = '{8'h03, 24'h00003F, 32, 32'h0,    16, 32'h1122,   0, 1, 6'h3F, 8'h11, 6'h00, 8'h22};
        vecs[4]  = '{8'h9F, 24'h000000, 32, 32'h0,    8,  32'h0,      1, 0, 6'h00, 8'h22, 6'h10, 8'hAA};
        vecs[5]  = '{8'h02, 24'h010005, 32, 32'hF,    4,  32'h0,      0, 1, 6'h05, 8'h00, 6'h06, 8'h00};
        vecs[6]  = '{8'h02, 24'h010005, 32, 32'h77,   8,  32'h0,      0, 1, 6'h05, 8'h77, 6'h06, 8'h00};
        vecs[7]  = '{8'h03, 24'h000005, 32, 32'h0,    0,  32'h0,      0, 1, 6'h05, 8'h77, 6'h10, 8'hAA};
        vecs[8]  = '{8'h03, 24'h000000, 8,  32'h0,    0,  32'h0,      0, 0, 6'h05, 8'h77, 6'h3F, 8'h11};
        vecs[9]  = '{8'h03, 24'hFFFFFF, 32, 32'h0,    24, 32'h112200, 0, 1, 6'h3F, 8'h11, 6'h00, 8'h22};
        vecs[10] = '{8'h02, 24'h000020, 20, 32'h0,    0,  32'h0,      0, 0, 6'h20, 8'h00, 6'h10, 8'hAA};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;

        // Reset values
        wait_clk(3);
        check("reset_miso",      spi.miso,    0);
        check("reset_miso_oe",   spi.miso_oe, 0);
        check("reset_cmd_err",   cmd_err,     0);
        check("reset_xfer_done", xfer_done,   0);
        check("reset_dbg_rdata", dbg_rdata,   0);
        rst_n = 1'b1;
        wait_clk(5);

        // Directed frames
        for (int i = 0; i < 11; i++) begin
            e0 = err_cnt;
            d0 = done_cnt;
            model_frame(vecs[i].cmd, vecs[i].addr, vecs[i].hdr_bits, vecs[i].data, vecs[i].data_bits,
                        m_rd, m_err, m_done);
            run_frame(vecs[i].cmd, vecs[i].addr, vecs[i].hdr_bits, vecs[i].data, vecs[i].data_bits,
                      rd, oe_bad);
            check($sformatf("vec%0d_cmd_err", i),   err_cnt - e0,  vecs[i].exp_err);
            check($sformatf("vec%0d_xfer_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_oe", i),        oe_bad,        0);
            if (vecs[i].data_bits > 0)
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            dbg_read(vecs[i].ca0, v);
            check($sformatf("vec%0d_mem0", i), v, vecs[i].cv0);
            dbg_read(vecs[i].ca1, v);
            check($sformatf("vec%0d_mem1", i), v, vecs[i].cv1);
        end

        // Reset during a read data byte; rest of that frame must be ignored
        e0 = err_cnt;
        d0 = done_cnt;
        spi.cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 32; i++) send_bit(((32'h03000010 >> (31 - i)) & 1) != 0, so, soe);
        for (int i = 0; i < 3; i++) send_bit(1'b0, so, soe);
        check("t6_oe_before_reset", soe, 1);
        rst_n = 1'b0;
        wait_clk(2);
        check("t6_miso_in_reset",    spi.miso,    0);
        check("t6_miso_oe_in_reset", spi.miso_oe, 0);
        rst_n = 1'b1;
        wait_clk(2);
        bad = 0;
        for (int i = 0; i < 13; i++) begin
            send_bit(1'b1, so, soe);
            if (so !== 1'b0 || soe !== 1'b0) bad++;
        end
        wait_clk(HALF);
        spi.cs_n = 1'b1;
        wait_clk(8);
        check("t6_ignored_bits", bad, 0);
        check("t6_no_xfer_done", done_cnt - d0, 0);
        check("t6_no_cmd_err",   err_cnt - e0,  0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        dbg_read(6'h10, v); check("t6_cleared_10", v, 0);
        dbg_read(6'h3F, v); check("t6_cleared_3f", v, 0);
        dbg_read(6'h05, v); check("t6_cleared_05", v, 0);
        d0 = done_cnt;
        run_frame(8'h02, 24'h000008, 32, 32'hC3, 8, rd, oe_bad);
        model_frame(8'h02, 24'h000008, 32, 32'hC3, 8, m_rd, m_err, m_done);
        run_frame(8'h03, 24'h000008, 32, 32'h0, 8, rd, oe_bad);
        check("t6_after_rdata",     rd, 32'hC3);
        check("t6_after_oe",        oe_bad, 0);
        check("t6_after_xfer_done", done_cnt - d0, 2);

        // Randomised frames against the reference model
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 7);
            if (r < 3)      cmd = 8'h02;
            else if (r < 6) cmd = 8'h03;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'h02 || cmd == 8'h03) cmd = 8'hA5;
            end
            addr = 24'($urandom);
            data = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                hb = $urandom_range(1, 31);
                db = 0;
            end else begin
                hb = 32;
                db = 8 * $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0 && db < 24) db += $urandom_range(1, 7);
            end
            e0 = err_cnt;
            d0 = done_cnt;
            model_frame(cmd, addr, hb, data, db, m_rd, m_err, m_done);
            run_frame(cmd, addr, hb, data, db, rd, oe_bad);
            check($sformatf("rnd%0d_cmd_err", n),   err_cnt - e0,  m_err);
            check($sformatf("rnd%0d_xfer_done", n), done_cnt - d0, m_done);
            check($sformatf("rnd%0d_oe", n),        oe_bad,        0);
            if (db > 0) check($sformatf("rnd%0d_rdata", n), rd, m_rd);
        end
        for (int a = 0; a < DEPTH; a++) begin
            dbg_read(6'(a), v);
            check($sformatf("final_mem_%0h", a), v, ref_mem[a]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
